// File: rtl/learning_score_controller.sv
// Piano-lesson score keeper: selects a song, requests notes from a player,
// judges key presses against each note and tallies hits and misses.
module learning_score_controller #(
    parameter int NUM_SONGS = 3,
    parameter int KEY_W     = 7,
    parameter int SCORE_W   = 8,
    parameter bit WRAP      = 1'b0,
    parameter int TIMEOUT   = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               next_song,
    input  logic               prev_song,
    input  logic               start,
    input  logic [KEY_W-1:0]   key_in,
    input  logic [KEY_W-1:0]   expected_note,
    input  logic               note_valid,
    input  logic               song_end,
    output logic [3:0]         song_number,
    output logic               play_start,
    output logic               note_req,
    output logic [SCORE_W-1:0] hit_count,
    output logic [SCORE_W-1:0] miss_count,
    output logic               busy,
    output logic               done
);

    localparam int                 TIMER_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]         LAST_SONG  = 4'(NUM_SONGS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_SELECT,
        S_REQ,
        S_WAIT_NOTE,
        S_WAIT_KEY,
        S_RELEASE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         song_q, song_d;
    logic [SCORE_W-1:0] hit_q, hit_d;
    logic [SCORE_W-1:0] miss_q, miss_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [KEY_W-1:0]   note_q, note_d;
    logic               play_start_q, play_start_d;
    logic               note_req_q, note_req_d;
    logic               next_prev_q, prev_prev_q, start_prev_q, key_prev_q;

    logic next_edge, prev_edge, start_edge, key_edge;

    // Any-bit key detection: adding a second key while one is held is not a new press.
    assign next_edge  = next_song & ~next_prev_q;
    assign prev_edge  = prev_song & ~prev_prev_q;
    assign start_edge = start & ~start_prev_q;
    assign key_edge   = (|key_in) & ~key_prev_q;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        song_d       = song_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        timer_d      = timer_q;
        note_d       = note_q;
        play_start_d = 1'b0;

        unique case (state_q)
            S_SELECT: begin
                if (next_edge && !prev_edge) begin
                    if (song_q < LAST_SONG)  song_d = song_q + 4'd1;
                    else if (WRAP)           song_d = 4'd0;
                end else if (prev_edge && !next_edge) begin
                    if (song_q > 4'd0)       song_d = song_q - 4'd1;
                    else if (WRAP)           song_d = LAST_SONG;
                end
                if (start_edge) begin
                    state_d      = S_REQ;
                    hit_d        = '0;
                    miss_d       = '0;
                    play_start_d = 1'b1;
                end
            end
            S_REQ: state_d = S_WAIT_NOTE;
            S_WAIT_NOTE: begin
                if (song_end) begin
                    state_d = S_DONE;
                end else if (note_valid) begin
                    note_d  = expected_note;
                    timer_d = '0;
                    state_d = S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                // A press landing on the timeout cycle is judged as a press.
                if (key_edge) begin
                    if (key_in == note_q) hit_d  = sat_inc(hit_q);
                    else                  miss_d = sat_inc(miss_q);
                    state_d = S_RELEASE;
                end else if (timer_q == TIMER_LAST) begin
                    miss_d  = sat_inc(miss_q);
                    state_d = S_REQ;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_RELEASE: begin
                if (key_in == '0) state_d = S_REQ;
            end
            S_DONE: begin
                if (start_edge) state_d = S_SELECT;
            end
            default: state_d = S_SELECT;
        endcase

        note_req_d = (state_d == S_REQ);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_SELECT;
            song_q       <= 4'd0;
            hit_q        <= '0;
            miss_q       <= '0;
            timer_q      <= '0;
            note_q       <= '0;
            play_start_q <= 1'b0;
            note_req_q   <= 1'b0;
            // Held-high inputs must not look like fresh presses once reset lifts.
            next_prev_q  <= 1'b1;
            prev_prev_q  <= 1'b1;
            start_prev_q <= 1'b1;
            key_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            timer_q      <= timer_d;
            note_q       <= note_d;
            play_start_q <= play_start_d;
            note_req_q   <= note_req_d;
            next_prev_q  <= next_song;
            prev_prev_q  <= prev_song;
            start_prev_q <= start;
            key_prev_q   <= |key_in;
        end
    end

    assign song_number = song_q;
    assign play_start  = play_start_q;
    assign note_req    = note_req_q;
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;
    assign busy        = (state_q != S_SELECT) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_learning_score_controller.sv
// Directed bench: two controllers (no-wrap with 2-bit scores, wrap with 8-bit scores)
// share stimulus; selection is table-driven, the play flow is hand-sequenced.
module tb_learning_score_controller;

    localparam int KEY_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             next_song, prev_song, start;
    logic [KEY_W-1:0] key_in, expected_note;
    logic             note_valid, song_end;

    logic [3:0] song_a, song_b;
    logic       play_a, play_b, nreq_a, nreq_b, busy_a, busy_b, done_a, done_b;
    logic [1:0] hit_a, miss_a;
    logic [7:0] hit_b, miss_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    learning_score_controller #(
        .NUM_SONGS(3), .KEY_W(KEY_W), .SCORE_W(2), .WRAP(1'b0), .TIMEOUT(16)
    ) u_dut_a (
        .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song),
        .start(start), .key_in(key_in), .expected_note(expected_note),
        .note_valid(note_valid), .song_end(song_end), .song_number(song_a),
        .play_start(play_a), .note_req(nreq_a), .hit_count(hit_a),
        .miss_count(miss_a), .busy(busy_a), .done(done_a)
    );

    learning_score_controller #(
        .NUM_SONGS(3), .KEY_W(KEY_W), .SCORE_W(8), .WRAP(1'b1), .TIMEOUT(16)
    ) u_dut_b (
        .clk(clk), .reset(reset), .next_song(next_song), .prev_song(prev_song),
        .start(start), .key_in(key_in), .expected_note(expected_note),
        .note_valid(note_valid), .song_end(song_end), .song_number(song_b),
        .play_start(play_b), .note_req(nreq_b), .hit_count(hit_b),
        .miss_count(miss_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       nxt;
        logic       prv;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
    } sel_vec_t;

    sel_vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_songs(input string name, input int ea, input int eb);
        check({name, " song_a"}, 32'(song_a), 32'(ea));
        check({name, " song_b"}, 32'(song_b), 32'(eb));
    endtask

    task automatic check_counts(input string name, input int ha, input int ma,
                                input int hb, input int mb);
        check({name, " hit_a"},  32'(hit_a),  32'(ha));
        check({name, " miss_a"}, 32'(miss_a), 32'(ma));
        check({name, " hit_b"},  32'(hit_b),  32'(hb));
        check({name, " miss_b"}, 32'(miss_b), 32'(mb));
    endtask

    task automatic check_flags(input string name, input logic eb, input logic ed,
                               input logic ep, input logic en);
        check({name, " busy"},       32'({busy_a, busy_b}), 32'({eb, eb}));
        check({name, " done"},       32'({done_a, done_b}), 32'({ed, ed}));
        check({name, " play_start"}, 32'({play_a, play_b}), 32'({ep, ep}));
        check({name, " note_req"},   32'({nreq_a, nreq_b}), 32'({en, en}));
    endtask

    // From WAIT_NOTE: present a note, press the matching key, release, back to WAIT_NOTE.
    task automatic do_hit(input logic [KEY_W-1:0] note);
        note_valid = 1'b1; expected_note = note; tick();
        note_valid = 1'b0; key_in = note;        tick();
        key_in = '0;                             tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'd1, 4'd1};
        vecs[1]  = '{1'b1, 1'b0, 4'd2, 4'd2};
        vecs[2]  = '{1'b1, 1'b0, 4'd2, 4'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'd2, 4'd1};
        vecs[4]  = '{1'b0, 1'b1, 4'd1, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 4'd0, 4'd2};
        vecs[6]  = '{1'b0, 1'b1, 4'd0, 4'd1};
        vecs[7]  = '{1'b1, 1'b1, 4'd0, 4'd1};
        vecs[8]  = '{1'b0, 1'b1, 4'd0, 4'd0};
        vecs[9]  = '{1'b0, 1'b1, 4'd0, 4'd2};
        vecs[10] = '{1'b1, 1'b0, 4'd1, 4'd0};
        vecs[11] = '{1'b1, 1'b1, 4'd1, 4'd0};

        reset = 1'b1; next_song = 1'b0; prev_song = 1'b0; start = 1'b0;
        key_in = '0; expected_note = '0; note_valid = 1'b0; song_end = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check_songs("reset", 0, 0);
        check_counts("reset", 0, 0, 0, 0);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Song selection: one press per row, released before the next.
        for (int i = 0; i < 12; i++) begin
            next_song = vecs[i].nxt;
            prev_song = vecs[i].prv;
            tick();
            check_songs($sformatf("select row %0d", i), int'(vecs[i].exp_a), int'(vecs[i].exp_b));
            next_song = 1'b0;
            prev_song = 1'b0;
            tick();
        end

        // Start and a correct note.
        start = 1'b1; tick();
        check_flags("start", 1'b1, 1'b0, 1'b1, 1'b1);
        start = 1'b0; tick();
        check_flags("req done", 1'b1, 1'b0, 1'b0, 1'b0);
        note_valid = 1'b1; expected_note = 7'b0000100; tick();
        note_valid = 1'b0; key_in = 7'b0000100; tick();
        check_counts("hit", 1, 0, 1, 0);
        tick();
        check_flags("held key", 1'b1, 1'b0, 1'b0, 1'b0);
        key_in = '0; tick();
        check_flags("release", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // Wrong key.
        note_valid = 1'b1; expected_note = 7'b0000100; tick();
        note_valid = 1'b0; key_in = 7'b0001000; tick();
        check_counts("wrong key", 1, 1, 1, 1);
        key_in = '0; tick(); tick();

        // Start and selection presses while busy are ignored.
        start = 1'b1; next_song = 1'b1; tick();
        check_flags("start busy", 1'b1, 1'b0, 1'b0, 1'b0);
        check_songs("select busy", 1, 0);
        start = 1'b0; next_song = 1'b0; tick();

        // Timeout: miss lands 16 cycles after note_valid.
        note_valid = 1'b1; expected_note = 7'b0000010; tick();
        note_valid = 1'b0;
        repeat (15) tick();
        check_counts("pre timeout", 1, 1, 1, 1);
        tick();
        check_counts("timeout", 1, 2, 1, 2);
        check_flags("timeout", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // Four more hits: 2-bit score saturates at 3.
        do_hit(7'b0000001);
        do_hit(7'b0010000);
        do_hit(7'b1000000);
        do_hit(7'b0000100);
        check_counts("saturate", 3, 2, 5, 2);

        // Press arriving on the timeout cycle counts as a press.
        note_valid = 1'b1; expected_note = 7'b0100000; tick();
        note_valid = 1'b0;
        repeat (15) tick();
        key_in = 7'b0100000; tick();
        check_counts("press at timeout", 3, 2, 6, 2);
        key_in = '0; tick(); tick();

        // song_end wins over note_valid.
        song_end = 1'b1; note_valid = 1'b1; tick();
        song_end = 1'b0; note_valid = 1'b0;
        check_flags("done", 1'b0, 1'b1, 1'b0, 1'b0);
        check_counts("done held", 3, 2, 6, 2);
        next_song = 1'b1; tick();
        check_songs("select in done", 1, 0);
        next_song = 1'b0; tick();
        start = 1'b1; tick();
        check_flags("leave done", 1'b0, 1'b0, 1'b0, 1'b0);
        check_songs("leave done", 1, 0);
        start = 1'b0; tick();

        // Reset during WAIT_KEY with start held high.
        start = 1'b1; tick();
        check_counts("restart clear", 0, 0, 0, 0);
        tick();
        note_valid = 1'b1; expected_note = 7'b0000100; tick();
        note_valid = 1'b0; key_in = 7'b0000001; tick();
        check_counts("pre reset", 0, 1, 0, 1);
        key_in = '0; tick(); tick();
        note_valid = 1'b1; tick();
        note_valid = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        check_flags("mid reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_counts("mid reset", 0, 0, 0, 0);
        check_songs("mid reset", 0, 0);
        tick(); tick();
        check_flags("start held", 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0; tick();
        start = 1'b1; tick();
        check_flags("start again", 1'b1, 1'b0, 1'b1, 1'b1);
        start = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
